// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared widths, phase decode constants and voice term helper for the PWM mixer
package audio_pkg;

    localparam int SAMPLE_W  = 7;
    localparam int MIX_W     = 9;
    localparam int FRAME_LEN = 512;

    localparam logic [MIX_W-1:0] PH_V1   = MIX_W'(0);
    localparam logic [MIX_W-1:0] PH_V2   = MIX_W'(1);
    localparam logic [MIX_W-1:0] PH_V3   = MIX_W'(2);
    localparam logic [MIX_W-1:0] PH_V4   = MIX_W'(3);
    localparam logic [MIX_W-1:0] PH_CAPT = MIX_W'(4);
    localparam logic [MIX_W-1:0] PH_LAST = MIX_W'(FRAME_LEN - 1);

    function automatic logic [MIX_W-1:0] voice_term(
        input logic [SAMPLE_W-1:0] sample,
        input logic                en,
        input logic [1:0]          atten
    );
        logic [SAMPLE_W-1:0] shifted;
        shifted = sample >> atten;
        return en ? MIX_W'(shifted) : '0;
    endfunction

endpackage

// File: rtl/pwm_frame_core.sv
// rtl/pwm_frame_core.sv - frame counter, played level register, duty comparator and frame strobe
module pwm_frame_core
    import audio_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic [MIX_W-1:0] pending_i,
    output logic [MIX_W-1:0] cnt_o,
    output logic [MIX_W-1:0] level_o,
    output logic             pwm_o,
    output logic             strobe_o
);

    logic [MIX_W-1:0] cnt_q;
    logic [MIX_W-1:0] level_q;
    logic             pwm_q;
    logic             strobe_q;

    // The counter wraps naturally because the frame length is 2**MIX_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            level_q  <= '0;
            pwm_q    <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_q + 1'b1;
            strobe_q <= (cnt_q == PH_LAST);
            pwm_q    <= enable_i & (cnt_q < level_q);
            if (cnt_q == PH_LAST) begin
                level_q <= pending_i;
            end
        end
    end

    assign cnt_o    = cnt_q;
    assign level_o  = level_q;
    assign pwm_o    = pwm_q;
    assign strobe_o = strobe_q;

endmodule

// File: rtl/audio_pwm_mixer.sv
// rtl/audio_pwm_mixer.sv - four-voice time-multiplexed mixer feeding a 512-clock PWM audio frame
module audio_pwm_mixer
    import audio_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] sample1,
    input  logic [SAMPLE_W-1:0] sample2,
    input  logic [SAMPLE_W-1:0] sample3,
    input  logic [SAMPLE_W-1:0] sample4,
    input  logic [3:0]          voice_en,
    input  logic [7:0]          atten,
    output logic                pwm_out,
    output logic                frame_strobe,
    output logic [MIX_W-1:0]    mix_level
);

    logic [MIX_W-1:0]    cnt;
    logic [MIX_W-1:0]    acc_q, acc_d;
    logic [MIX_W-1:0]    pending_q, pending_d;
    logic [SAMPLE_W-1:0] sel_sample;
    logic                sel_en;
    logic [1:0]          sel_atten;
    logic [MIX_W-1:0]    term;

    // Only the voice owning the current phase is routed to the single adder.
    always_comb begin
        sel_sample = '0;
        sel_en     = 1'b0;
        sel_atten  = 2'd0;
        case (cnt[1:0])
            2'd0: begin sel_sample = sample1; sel_en = voice_en[0]; sel_atten = atten[1:0]; end
            2'd1: begin sel_sample = sample2; sel_en = voice_en[1]; sel_atten = atten[3:2]; end
            2'd2: begin sel_sample = sample3; sel_en = voice_en[2]; sel_atten = atten[5:4]; end
            default: begin sel_sample = sample4; sel_en = voice_en[3]; sel_atten = atten[7:6]; end
        endcase
    end

    assign term = voice_term(sel_sample, sel_en, sel_atten);

    always_comb begin
        acc_d     = acc_q;
        pending_d = pending_q;
        if (cnt == PH_V1) begin
            acc_d = term;
        end else if (cnt <= PH_V4) begin
            acc_d = acc_q + term;
        end
        if (cnt == PH_CAPT) begin
            pending_d = acc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            pending_q <= '0;
        end else begin
            acc_q     <= acc_d;
            pending_q <= pending_d;
        end
    end

    pwm_frame_core u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable_i  (enable),
        .pending_i (pending_q),
        .cnt_o     (cnt),
        .level_o   (mix_level),
        .pwm_o     (pwm_out),
        .strobe_o  (frame_strobe)
    );

endmodule
